exec_run_ctrl: RTL
==================

Name: exec_run_ctrl

Overview:
- Run sequencer for the 3-bit computer execute datapath.
- Serially loads registers A/B/C through the datapath's init shift path, then releases the pipeline to run.
- While running, it watches for halt and captures every emitted 3-bit output into an output FIFO for the host. A cycle watchdog bounds runaway programs.

Parameters:
REG_WIDTH, 48, width of A/B/C; number of accepted load beats
FIFO_DEPTH, 16, output FIFO entries (power of two, >=2)
CYC_W, 20, width of run cycle counter; watchdog limit is 2^CYC_W-1 cycles

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous to clk, active-high
cmd_start  in  1  pulse: clear state, begin load (honoured only in IDLE/DONE)
load_valid  in  1  load beat valid
load_data  in  3  beat bits {C,B,A}: bit0->A, bit1->B, bit2->C, MSB-first
load_ready  out  1  high only in LOAD
init_regs  out  1  to datapath: shift in one bit per asserted cycle
a_bit  out  1  to datapath A_lsb_opcode_0
b_bit  out  1  to datapath B_lsb_opcode_1
c_bit  out  1  to datapath C_lsb_opcode_2
core_enable  out  1  pipeline advance enable, high only in RUN
halt_ex  in  1  datapath execute-stage halt
out_valid_in  in  1  datapath output strobe
reg_out_in  in  3  datapath output value
out_data  out  3  FIFO head
out_avail  out  1  FIFO non-empty
out_pop  in  1  host pop; ignored when empty
overflow  out  1  sticky: output dropped on full FIFO
timeout  out  1  sticky: watchdog expired
busy  out  1  state is LOAD or RUN
done  out  1  state is DONE
cycle_count  out  CYC_W  RUN cycles elapsed, saturating

Behaviour:
- Reset (rst high at clk edge) overrides everything, including mid-load or mid-run.
  - State becomes IDLE and the FIFO is emptied.
  - All outputs are 0, including cycle_count, overflow and timeout.
- Registered FSM: IDLE -> LOAD -> RUN -> DONE.
- IDLE / DONE:
  - cmd_start -> LOAD, same edge.
  - Clears beat counter, cycle_count, overflow, timeout and FIFO.
  - Otherwise hold.
- LOAD:
  - load_ready=1.
  - init_regs = load_valid (combinational), so the datapath shifts only on accepted beats.
  - a_bit/b_bit/c_bit = load_data[0]/[1]/[2] (combinational).
  - Beat counter increments per accepted beat. On the REG_WIDTH-th accepted beat -> RUN next cycle.
  - load_valid low stalls the load with no shift. cmd_start is ignored.
- RUN:
  - core_enable=1; init_regs=0.
  - cycle_count increments each RUN cycle, saturating at 2^CYC_W-1.
  - halt_ex -> DONE.
  - If cycle_count == 2^CYC_W-1 and no halt_ex -> DONE with timeout=1.
  - halt_ex and watchdog expiry in the same cycle: halt wins, timeout stays 0.
- Output capture:
  - Accepted only in RUN. An out_valid_in in the same cycle as halt_ex is still captured.
  - Push succeeds if the FIFO is not full, or if it is full and a pop occurs that cycle. Otherwise the value is dropped and overflow is set.
- FIFO:
  - Show-ahead: out_data is valid whenever out_avail=1.
  - Pop and push in the same cycle keep the count.
  - Popping is allowed in every state; DONE still drains.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra count bit.
- busy = LOAD|RUN; done = DONE; both registered with the state.
- sticky flags clear only on reset or an accepted cmd_start.
- Latency:
  - cmd_start to load_ready = 1 cycle.
  - Last beat to core_enable = 1 cycle.
  - halt_ex to done = 1 cycle.
  - Capture to out_avail = 1 cycle.

Test Plan:
- Reset/idle: hold rst 2 cycles -> all outputs 0, state IDLE; cmd_start asserted during rst -> ignored.
- Load: cmd_start, then 48 beats with 1 idle gap each 8 beats; A=729, B=0, C=0 MSB-first -> init_regs high exactly 48 cycles; core_enable rises 1 cycle after beat 48; a_bit stream matches 729.
- Run/capture: in RUN, drive out_valid_in with values 4,6,3,5 then halt_ex with simultaneous value 0 -> FIFO pops 4,6,3,5,0; done=1 next cycle; timeout=0.
- FIFO full: 16 outputs without pop, then a 17th -> overflow=1 and 17th dropped. 17th issued with concurrent pop -> accepted, count stays 16, overflow=0.
- Watchdog: CYC_W=4, no halt -> DONE after 15 RUN cycles, timeout=1, cycle_count=15. Halt on cycle 15 -> timeout=0.
- Reset mid-op: assert rst at beat 20 of LOAD and again mid-RUN -> next cycle IDLE, init_regs=0, core_enable=0, FIFO empty; cmd_start in RUN ignored.

Source files
------------

// File: rtl/exec_run_ctrl.sv
// Run sequencer for the 3-bit execute datapath: serial A/B/C load, run release,
// output capture FIFO for the host and a saturating cycle watchdog.
module exec_run_ctrl #(
    parameter int unsigned REG_WIDTH  = 48,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CYC_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             load_valid,
    input  logic [2:0]       load_data,
    output logic             load_ready,
    output logic             init_regs,
    output logic             a_bit,
    output logic             b_bit,
    output logic             c_bit,
    output logic             core_enable,
    input  logic             halt_ex,
    input  logic             out_valid_in,
    input  logic [2:0]       reg_out_in,
    output logic [2:0]       out_data,
    output logic             out_avail,
    input  logic             out_pop,
    output logic             overflow,
    output logic             timeout,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycle_count
);

    localparam int unsigned BEAT_W = $clog2(REG_WIDTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CYC_W-1:0]  CYC_MAX   = '1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REG_WIDTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [CYC_W-1:0]  r_cyc;
    logic              r_overflow;
    logic              r_timeout;
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [2:0]        r_mem [FIFO_DEPTH];

    logic w_in_load;
    logic w_in_run;
    logic w_start_ok;
    logic w_beat_ok;
    logic w_last_beat;
    logic w_wd_exp;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_cap;
    logic w_push;
    logic w_drop;

    assign w_in_load   = (r_state == S_LOAD);
    assign w_in_run    = (r_state == S_RUN);
    assign w_start_ok  = cmd_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_beat_ok   = w_in_load && load_valid;
    assign w_last_beat = w_beat_ok && (r_beat == LAST_BEAT);
    assign w_wd_exp    = (r_cyc == CYC_MAX);

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = out_pop && !w_empty;
    assign w_cap   = w_in_run && out_valid_in;
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && w_full && !w_pop;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (cmd_start) w_state_nxt = S_LOAD;
            S_LOAD:         if (w_last_beat) w_state_nxt = S_RUN;
            S_RUN:          if (halt_ex || w_wd_exp) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters, sticky flags and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_cyc      <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_beat     <= '0;
                r_cyc      <= '0;
                r_overflow <= 1'b0;
                r_timeout  <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_beat_ok) r_beat <= r_beat + 1'b1;
                if (w_in_run && !w_wd_exp) r_cyc <= r_cyc + 1'b1;
                if (w_drop) r_overflow <= 1'b1;
                // Halt in the expiry cycle takes priority over the watchdog.
                if (w_in_run && w_wd_exp && !halt_ex) r_timeout <= 1'b1;
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observable through the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= reg_out_in;
    end

    assign load_ready  = w_in_load;
    assign init_regs   = w_beat_ok;
    assign a_bit       = w_in_load && load_data[0];
    assign b_bit       = w_in_load && load_data[1];
    assign c_bit       = w_in_load && load_data[2];
    assign core_enable = w_in_run;
    assign out_avail   = !w_empty;
    assign out_data    = w_empty ? 3'b000 : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign overflow    = r_overflow;
    assign timeout     = r_timeout;
    assign busy        = w_in_load || w_in_run;
    assign done        = (r_state == S_DONE);
    assign cycle_count = r_cyc;

endmodule
